// File: rtl/surf_cout_align_ctrl.sv
// -----------------------------------------------------------------------------
// surf_cout_align_ctrl
//
// Automatic link-alignment sequencer for one SURF COUT receive path. It resets
// the ISERDES, sweeps every IDELAY tap while the SURF sends training, and keeps
// the widest run of stable taps as the eye. It then loads the centre of that eye
// and issues bitslips until the received word equals TRAIN_SEQUENCE.
//
// Ports
//   aclk, aresetn      sysclk and synchronous active-low reset
//   start_i            pulse; starts a run from IDLE/LOCKED/FAIL
//   abort_i            level; returns to IDLE at the next edge (beats start_i)
//   cout_data_i/valid  deserialized COUT word and its qualifier
//   iserdes_rst_o      ISERDES reset, high for RST_CYCLES cycles
//   idelay_value_o     IDELAY tap; holds the last loaded value
//   idelay_load_o      one-cycle IDELAY load strobe
//   bitslip_o          one-cycle ISERDES bitslip strobe
//   busy_o             sequence in progress
//   locked_o, fail_o   result of the last run
//   eye_start_o        first tap of the best stable run
//   eye_len_o          length of the best stable run (0..64)
//   slip_count_o       bitslips issued in the last run
// -----------------------------------------------------------------------------
module surf_cout_align_ctrl #(
  parameter logic [31:0] TRAIN_SEQUENCE = 32'hA55A6996,
  parameter int          RST_CYCLES     = 16,
  parameter int          SETTLE_CYCLES  = 64,
  parameter int          CHECK_WORDS    = 16,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter int          MIN_EYE        = 4,
  parameter int          MAX_SLIPS      = 32
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] cout_data_i,
  input  logic        cout_valid_i,
  output logic        iserdes_rst_o,
  output logic [5:0]  idelay_value_o,
  output logic        idelay_load_o,
  output logic        bitslip_o,
  output logic        busy_o,
  output logic        locked_o,
  output logic        fail_o,
  output logic [5:0]  eye_start_o,
  output logic [6:0]  eye_len_o,
  output logic [5:0]  slip_count_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_RST, S_LOAD, S_SETTLE, S_CHECK, S_EVAL,
    S_CENTER, S_SETTLE_C, S_SCHECK, S_SLIP, S_LOCKED, S_FAIL
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;             // reset / settle / timeout counter
  logic [5:0]  tap_q, tap_d;             // tap under test during the sweep
  logic [5:0]  idelay_value_q, idelay_value_d;
  logic [7:0]  match_q, match_d;
  logic        seeded_q, seeded_d;       // first valid word of a CHECK seen
  logic [31:0] prev_q, prev_d;
  logic        good_q, good_d;           // verdict on the tap just checked
  logic [5:0]  cur_start_q, cur_start_d;
  logic [6:0]  cur_len_q, cur_len_d;
  logic [5:0]  eye_start_q, eye_start_d;
  logic [6:0]  eye_len_q, eye_len_d;
  logic [5:0]  slip_q, slip_d;

  // Shared decode
  logic        rst_done, settle_done, match_done, timeout_hit;
  logic        word_eq_prev, word_eq_train, eye_ok, slip_at_max, tap_last;
  logic [6:0]  run_len, centre_sum;
  logic [5:0]  run_start, centre;

  assign rst_done      = (cnt_q == 16'(RST_CYCLES - 1));
  assign settle_done   = (cnt_q == 16'(SETTLE_CYCLES - 1));
  assign timeout_hit   = ((cnt_q + 16'd1) == 16'(TIMEOUT_CYCLES));
  assign match_done    = ((match_q + 8'd1) == 8'(CHECK_WORDS));
  assign word_eq_prev  = (cout_data_i == prev_q);
  assign word_eq_train = (cout_data_i == TRAIN_SEQUENCE);
  assign eye_ok        = (eye_len_q >= 7'(MIN_EYE));
  assign slip_at_max   = (slip_q == 6'(MAX_SLIPS));
  assign tap_last      = (tap_q == 6'd63);

  // Run as it stands after folding in the current tap's verdict.
  assign run_len   = good_q ? cur_len_q + 7'd1 : cur_len_q;
  assign run_start = (good_q && cur_len_q == 7'd0) ? tap_q : cur_start_q;

  // start + len <= 64, so start + len/2 always fits in six bits.
  assign centre_sum = 7'(eye_start_q) + (eye_len_q >> 1);
  assign centre     = centre_sum[5:0];

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      tap_q          <= '0;
      idelay_value_q <= '0;
      match_q        <= '0;
      seeded_q       <= 1'b0;
      prev_q         <= '0;
      good_q         <= 1'b0;
      cur_start_q    <= '0;
      cur_len_q      <= '0;
      eye_start_q    <= '0;
      eye_len_q      <= '0;
      slip_q         <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tap_q          <= tap_d;
      idelay_value_q <= idelay_value_d;
      match_q        <= match_d;
      seeded_q       <= seeded_d;
      prev_q         <= prev_d;
      good_q         <= good_d;
      cur_start_q    <= cur_start_d;
      cur_len_q      <= cur_len_d;
      eye_start_q    <= eye_start_d;
      eye_len_q      <= eye_len_d;
      slip_q         <= slip_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top of each always_comb guarantees
  // every path drives the signal, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_LOCKED, S_FAIL: if (start_i) state_d = S_RST;
        S_RST:      if (rst_done) state_d = S_LOAD;
        S_LOAD:     state_d = S_SETTLE;
        S_SETTLE:   if (settle_done) state_d = S_CHECK;
        S_CHECK: begin
          if (cout_valid_i) begin
            if (seeded_q && (!word_eq_prev || match_done)) state_d = S_EVAL;
          end else if (timeout_hit) begin
            state_d = S_EVAL;
          end
        end
        S_EVAL:     state_d = tap_last ? S_CENTER : S_LOAD;
        S_CENTER:   state_d = eye_ok ? S_SETTLE_C : S_FAIL;
        S_SETTLE_C: if (settle_done) state_d = S_SCHECK;
        S_SCHECK: begin
          if (cout_valid_i) begin
            if (!word_eq_train)  state_d = S_SLIP;
            else if (match_done) state_d = S_LOCKED;
          end else if (timeout_hit) begin
            state_d = S_SLIP;
          end
        end
        S_SLIP:     state_d = slip_at_max ? S_FAIL : S_SETTLE_C;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath next values (counters, eye tracking, slip count)
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d          = '0;
    tap_d          = tap_q;
    match_d        = match_q;
    seeded_d       = seeded_q;
    prev_d         = prev_q;
    good_d         = good_q;
    cur_start_d    = cur_start_q;
    cur_len_d      = cur_len_q;
    eye_start_d    = eye_start_q;
    eye_len_d      = eye_len_q;
    slip_d         = slip_q;
    idelay_value_d = idelay_value_o;

    case (state_q)
      S_IDLE, S_LOCKED, S_FAIL: begin
        // abort wins over start, so the eye survives an abort+start cycle.
        if (start_i && !abort_i) begin
          tap_d       = '0;
          cur_start_d = '0;
          cur_len_d   = '0;
          eye_start_d = '0;
          eye_len_d   = '0;
          slip_d      = '0;
        end
      end
      S_RST: if (!rst_done) cnt_d = cnt_q + 16'd1;
      S_SETTLE, S_SETTLE_C: begin
        if (!settle_done) cnt_d = cnt_q + 16'd1;
        match_d  = '0;
        seeded_d = 1'b0;
      end
      S_CHECK: begin
        if (cout_valid_i) begin
          seeded_d = 1'b1;
          prev_d   = cout_data_i;
          if (seeded_q) begin
            good_d = word_eq_prev;
            if (word_eq_prev) match_d = match_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (timeout_hit) good_d = 1'b0;
        end
      end
      S_EVAL: begin
        cur_start_d = run_start;
        cur_len_d   = run_len;
        // A bad tap or the end of the sweep closes the run; ties keep the
        // earlier run because only a strictly longer one replaces it.
        if (!good_q || tap_last) begin
          if (run_len > eye_len_q) begin
            eye_start_d = run_start;
            eye_len_d   = run_len;
          end
          cur_len_d = '0;
        end
        if (!tap_last) tap_d = tap_q + 6'd1;
      end
      S_SCHECK: begin
        if (cout_valid_i) begin
          if (word_eq_train) match_d = match_q + 8'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_SLIP: if (!slip_at_max) slip_d = slip_q + 6'd1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    iserdes_rst_o  = (state_q == S_RST);
    idelay_load_o  = 1'b0;
    bitslip_o      = 1'b0;
    idelay_value_o = idelay_value_q;
    busy_o         = !(state_q inside {S_IDLE, S_LOCKED, S_FAIL});
    locked_o       = (state_q == S_LOCKED);
    fail_o         = (state_q == S_FAIL);
    eye_start_o    = eye_start_q;
    eye_len_o      = eye_len_q;
    slip_count_o   = slip_q;

    case (state_q)
      S_LOAD: begin
        idelay_value_o = tap_q;
        idelay_load_o  = 1'b1;
      end
      S_CENTER: begin
        if (eye_ok) begin
          idelay_value_o = centre;
          idelay_load_o  = 1'b1;
        end
      end
      S_SLIP: bitslip_o = !slip_at_max;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_surf_cout_align_ctrl.sv
// -----------------------------------------------------------------------------
// tb_surf_cout_align_ctrl
//
// Directed bench for surf_cout_align_ctrl. A small PHY model follows the
// IDELAY tap and bitslip strobes and returns either the training word, random
// data, a rotated training word, or nothing, depending on the scenario mode.
// A monitor counts ISERDES reset cycles, load strobes and bitslip pulses.
// The timeout is shortened so the all-timeout sweep stays short.
// -----------------------------------------------------------------------------
module tb_surf_cout_align_ctrl;

  localparam logic [31:0] TRAIN = 32'hA55A6996;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        start_i;
  logic        abort_i;
  logic [31:0] cout_data_i;
  logic        cout_valid_i;
  logic        iserdes_rst_o;
  logic [5:0]  idelay_value_o;
  logic        idelay_load_o;
  logic        bitslip_o;
  logic        busy_o;
  logic        locked_o;
  logic        fail_o;
  logic [5:0]  eye_start_o;
  logic [6:0]  eye_len_o;
  logic [5:0]  slip_count_o;

  always #5 aclk = ~aclk;

  surf_cout_align_ctrl #(.TIMEOUT_CYCLES(128)) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .cout_data_i    (cout_data_i),
    .cout_valid_i   (cout_valid_i),
    .iserdes_rst_o  (iserdes_rst_o),
    .idelay_value_o (idelay_value_o),
    .idelay_load_o  (idelay_load_o),
    .bitslip_o      (bitslip_o),
    .busy_o         (busy_o),
    .locked_o       (locked_o),
    .fail_o         (fail_o),
    .eye_start_o    (eye_start_o),
    .eye_len_o      (eye_len_o),
    .slip_count_o   (slip_count_o)
  );

  // Scenario: 0 always stable, 1 stable on 10..19/40..49, 2 stable on 60..63,
  // 3 stable but rotated by 3 bits, 4 no valid words.
  int         mode;
  logic       clr_mon;
  int         rst_hi, load_cnt, load_seq_err, slips, strobe_err;
  logic [5:0] model_tap, last_load;
  logic       prev_strobe;
  int         pass_cnt  = 0;
  int         total_cnt = 0;

  function automatic logic [31:0] rotl(input logic [31:0] w, input int r);
    if (r == 0) return w;
    return (w << r) | (w >> (32 - r));
  endfunction

  function automatic logic tap_stable(input int m, input logic [5:0] t);
    case (m)
      1:       return (t >= 6'd10 && t <= 6'd19) || (t >= 6'd40 && t <= 6'd49);
      2:       return t >= 6'd60;
      default: return 1'b1;
    endcase
  endfunction

  // Monitor + PHY model, evaluated on the falling edge away from DUT updates.
  always @(negedge aclk) begin
    if (clr_mon) begin
      rst_hi = 0; load_cnt = 0; load_seq_err = 0; slips = 0; strobe_err = 0;
      model_tap = '0; last_load = '0;
    end else begin
      if (iserdes_rst_o) rst_hi++;
      if (idelay_load_o) begin
        if (load_cnt < 64 && idelay_value_o != 6'(load_cnt)) load_seq_err++;
        load_cnt++;
        model_tap = idelay_value_o;
        last_load = idelay_value_o;
      end
      if (bitslip_o) slips++;
      if ((idelay_load_o && bitslip_o) || (prev_strobe && (idelay_load_o || bitslip_o)))
        strobe_err++;
    end
    prev_strobe  = idelay_load_o | bitslip_o;
    cout_valid_i = (mode != 4);
    if (mode == 3)                          cout_data_i = rotl(TRAIN, (35 - slips) % 32);
    else if (tap_stable(mode, model_tap))   cout_data_i = TRAIN;
    else                                    cout_data_i = $urandom;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic start_pulse();
    start_i = 1'b1;
    clr_mon = 1'b1;
    tick();
    start_i = 1'b0;
    clr_mon = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy_o && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {31'b0, busy_o}, 32'd0);
  endtask

  initial begin
    aresetn = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    clr_mon = 1'b1;
    mode    = 0;
    repeat (3) tick();
    chk("reset_outputs", {1'b0, iserdes_rst_o, idelay_load_o, bitslip_o, busy_o, locked_o,
        fail_o, idelay_value_o, eye_start_o, eye_len_o, slip_count_o}, 32'd0);
    aresetn = 1'b1;
    clr_mon = 1'b0;
    tick();

    // Constant training word: full eye, centre 32, lock without slips.
    mode = 0;
    start_pulse();
    chk("t1_rst_high_after_start", {31'b0, iserdes_rst_o}, 32'd1);
    wait_idle("t1_done", 8000);
    chk("t1_rst_cycles", rst_hi, 16);
    chk("t1_load_count", load_cnt, 65);
    chk("t1_load_sequence", load_seq_err, 0);
    chk("t1_eye_start", {26'b0, eye_start_o}, 0);
    chk("t1_eye_len", {25'b0, eye_len_o}, 64);
    chk("t1_centre", {26'b0, last_load}, 32);
    chk("t1_locked_fail", {30'b0, locked_o, fail_o}, 32'b10);
    chk("t1_slip_count", {26'b0, slip_count_o}, 0);
    chk("t1_slip_pulses", slips, 0);
    chk("t1_strobe_rules", strobe_err, 0);

    // abort together with start: abort wins, locked clears, eye retained.
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("abort_over_start", {29'b0, busy_o, locked_o, fail_o}, 0);
    chk("abort_keeps_eye", {25'b0, eye_len_o}, 64);

    // Two equal eyes: earlier wins.
    mode = 1;
    start_pulse();
    wait_idle("t2_done", 8000);
    chk("t2_eye_start", {26'b0, eye_start_o}, 10);
    chk("t2_eye_len", {25'b0, eye_len_o}, 10);
    chk("t2_centre", {26'b0, last_load}, 15);
    chk("t2_locked", {31'b0, locked_o}, 1);

    // Eye at top of range is closed at tap 63, no wrap.
    mode = 2;
    start_pulse();
    wait_idle("t3_done", 8000);
    chk("t3_eye_start", {26'b0, eye_start_o}, 60);
    chk("t3_eye_len", {25'b0, eye_len_o}, 4);
    chk("t3_centre", {26'b0, last_load}, 62);
    chk("t3_load_count", load_cnt, 65);
    chk("t3_locked", {31'b0, locked_o}, 1);

    // Word rotated by 3: three bitslips then lock.
    mode = 3;
    start_pulse();
    wait_idle("t4_done", 8000);
    chk("t4_slip_pulses", slips, 3);
    chk("t4_slip_count", {26'b0, slip_count_o}, 3);
    chk("t4_locked", {31'b0, locked_o}, 1);
    chk("t4_strobe_rules", strobe_err, 0);

    // No valid words: every tap times out, no eye, FAIL.
    mode = 4;
    start_pulse();
    wait_idle("t5_done", 14000);
    chk("t5_eye_len", {25'b0, eye_len_o}, 0);
    chk("t5_fail_locked_busy", {29'b0, fail_o, locked_o, busy_o}, 32'b100);
    chk("t5_load_count", load_cnt, 64);
    chk("t5_slip_pulses", slips, 0);

    // Abort during SETTLE at tap 20, then rerun.
    mode = 0;
    start_pulse();
    begin
      int n = 0;
      while (load_cnt < 21 && n < 3000) begin
        tick();
        n++;
      end
    end
    chk("t6_reached_tap20", load_cnt, 21);
    repeat (5) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("t6_abort_idle", {26'b0, busy_o, locked_o, fail_o, iserdes_rst_o, idelay_load_o,
        bitslip_o}, 0);
    chk("t6_abort_keeps_tap", {26'b0, idelay_value_o}, 20);
    start_pulse();
    chk("t6_rerun_rst", {31'b0, iserdes_rst_o}, 1);
    wait_idle("t6_done", 8000);
    chk("t6_rst_cycles", rst_hi, 16);
    chk("t6_load_count", load_cnt, 65);
    chk("t6_locked", {31'b0, locked_o}, 1);

    // Synchronous reset mid-sequence.
    start_pulse();
    repeat (100) tick();
    aresetn = 1'b0;
    tick();
    chk("midrun_reset_outputs", {1'b0, iserdes_rst_o, idelay_load_o, bitslip_o, busy_o,
        locked_o, fail_o, idelay_value_o, eye_start_o, eye_len_o, slip_count_o}, 32'd0);
    aresetn = 1'b1;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
